// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the single ROB writeback port between NUM_REQ
// execution units. The winner is picked combinationally from rr_ptr_q onward,
// its payload is registered and presented to the ROB one cycle later.
//
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset
//   flush_i                drop in-flight writeback, suppress grants, reset pointer
//   req_valid_i            per-requester result available
//   req_ready_o            one-hot grant (combinational from valid, pointer, flush)
//   req_rob_idx_i          packed ROB indices, slice i = [i*ROB_IDX_W +: ROB_IDX_W]
//   req_result_i           packed results, slice i = [i*DATA_W +: DATA_W]
//   req_new_pc_i           packed next PCs
//   req_branch_taken_i     per-requester branch taken flag
//   wb_valid_o, wb_*_o     registered writeback toward the ROB
//   grant_idx_o            requester index held in the wb register (0 when idle)
module wb_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ROB_IDX_W = 3,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           flush_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx_i,
    input  logic [NUM_REQ*DATA_W-1:0]      req_result_i,
    input  logic [NUM_REQ*DATA_W-1:0]      req_new_pc_i,
    input  logic [NUM_REQ-1:0]             req_branch_taken_i,
    output logic                           wb_valid_o,
    output logic [ROB_IDX_W-1:0]           wb_rob_idx_o,
    output logic [DATA_W-1:0]              wb_result_o,
    output logic [DATA_W-1:0]              wb_new_pc_o,
    output logic                           wb_branch_taken_o,
    output logic [$clog2(NUM_REQ)-1:0]     grant_idx_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] grant_idx_c;
    logic [IDX_W-1:0] cand_c;
    logic             grant_any_c;
    logic [NUM_REQ-1:0] grant_c;

    // Circular priority search starting at rr_ptr_q; flush suppresses any grant.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        cand_c      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand_c = IDX_W'((32'(rr_ptr_q) + 32'(j)) % NUM_REQ);
            if (!grant_any_c && !flush_i && req_valid_i[cand_c]) begin
                grant_any_c     = 1'b1;
                grant_idx_c     = cand_c;
                grant_c[cand_c] = 1'b1;
            end
        end
    end

    assign req_ready_o = grant_c;

    // Pointer and writeback register; payload is zeroed whenever nothing is granted.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush_i) begin
            rr_ptr_q          <= '0;
            wb_valid_o        <= 1'b0;
            wb_rob_idx_o      <= '0;
            wb_result_o       <= '0;
            wb_new_pc_o       <= '0;
            wb_branch_taken_o <= 1'b0;
            grant_idx_o       <= '0;
        end else if (grant_any_c) begin
            rr_ptr_q          <= (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx_c + IDX_W'(1);
            wb_valid_o        <= 1'b1;
            wb_rob_idx_o      <= req_rob_idx_i[32'(grant_idx_c) * ROB_IDX_W +: ROB_IDX_W];
            wb_result_o       <= req_result_i[32'(grant_idx_c) * DATA_W +: DATA_W];
            wb_new_pc_o       <= req_new_pc_i[32'(grant_idx_c) * DATA_W +: DATA_W];
            wb_branch_taken_o <= req_branch_taken_i[grant_idx_c];
            grant_idx_o       <= grant_idx_c;
        end else begin
            wb_valid_o        <= 1'b0;
            wb_rob_idx_o      <= '0;
            wb_result_o       <= '0;
            wb_new_pc_o       <= '0;
            wb_branch_taken_o <= 1'b0;
            grant_idx_o       <= '0;
        end
    end

endmodule
